parking_occupancy_counter: RTL and testbench
============================================

Name: parking_occupancy_counter

Overview:
Downstream stage of the entry/exit detection FSM. It consumes the single-cycle E (entry) and S (exit) pulses and keeps the live car count for the lot. The count is held in binary and in 2-digit BCD for the display driver. The block also flags full/empty and records sticky over/underflow errors for the supervisor logic.

Parameters:
CAPACITY, 20, lot size in cars; legal range 1..99 (elaboration error otherwise)
CNT_W, 7, width of binary count; must satisfy 2**CNT_W > CAPACITY (elaboration error otherwise)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear of count and errors
e_in  input  1  entry pulse from detection FSM
s_in  input  1  exit pulse from detection FSM
count  output  CNT_W  current occupancy, binary
bcd_tens  output  4  occupancy tens digit
bcd_ones  output  4  occupancy ones digit
full  output  1  count == CAPACITY
empty  output  1  count == 0
chg  output  1  one-cycle pulse, count changed this cycle
ovf_err  output  1  sticky: entry seen while full
udf_err  output  1  sticky: exit seen while empty

Behaviour:
- Reset (async, rst=1): count=0, bcd_tens=0, bcd_ones=0, empty=1, full=0, chg=0, ovf_err=0, udf_err=0; internal edge registers e_d=s_d=0.
- Edge detection: ev_e = e_in & ~e_d; ev_s = s_in & ~s_d. e_d and s_d update every clock, including during clr. An input held high for N cycles counts once.
- Latency: 1 clock. The event is sampled at edge k; count, BCD, full, empty and chg are valid after edge k.
- Priority per clock edge: clr > simultaneous events > single event.
- clr=1: count=0, BCD=0, ovf_err=0, udf_err=0, chg=0. Events in the same cycle are discarded.
- ev_e & ev_s together: count unchanged, chg=0, no error set.
- ev_e alone, count<CAPACITY: count+1, chg=1.
- ev_e alone, count==CAPACITY: count holds, chg=0, ovf_err<=1.
- ev_s alone, count>0: count-1, chg=1.
- ev_s alone, count==0: count holds, chg=0, udf_err<=1.
- BCD is maintained incrementally, with no binary-to-BCD divide.
  - Increment: ones 9->0 with tens+1, otherwise ones+1.
  - Decrement: ones 0->9 with tens-1, otherwise ones-1.
  - Invariant every cycle: 10*bcd_tens + bcd_ones == count.
- full and empty are registered and updated on the same edge as count, so they never disagree with count.
- Error flags are sticky until clr or rst. The count keeps working normally while an error flag is set.
- rst asserted mid-operation: all outputs take their reset values immediately (asynchronous). A pulse present on the first edge after rst release is counted only if it rises after release; e_d=0 means a level already high at release counts once.

Decomposition:
- Shared package parking_pkg:
  - localparam CAPACITY default
  - BCD digit width (4)
  - BCD_MAX_DIGIT (9)
  - Shared with the FSM and display driver.
- Sub-module bcd_updown_counter:
  - 2-digit BCD register
  - inputs inc, dec, clr
  - outputs tens, ones
  - The parent guarantees inc and dec are never both high and handles the saturation decision.
- Binary count, flags and edge detection stay in the parent.

Test Plan:
1. Assert rst for 3 cycles, then release -> count=0, bcd=0/0, empty=1, full=0, chg=0, ovf_err=0, udf_err=0.
2. 12 isolated e_in pulses, 3 cycles apart -> count=12, bcd=1/2, chg seen exactly 12 times. On the 10th pulse the BCD goes 0/9 -> 1/0.
3. CAPACITY=20: 20 entries then 1 more entry -> full=1, count=20, ovf_err=1, no chg on the 21st. Then 1 exit -> count=19, full=0, ovf_err still 1.
4. At count=5, e_in and s_in high in the same cycle -> count=5, chg=0, no error. Next, e_in held high for 4 cycles -> count=6, exactly one chg.
5. At count=0, send an s_in pulse -> udf_err=1, count=0. Then clr together with an e_in pulse -> count=0, both error flags 0, chg=0.
6. At count=7, assert rst asynchronously between clock edges -> outputs return to reset values before the next edge. After release, 3 entries -> count=3, bcd=0/3.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared constants for the parking lot datapath (detection FSM, occupancy
// counter and display driver).
package parking_pkg;

    // Default lot size in cars.
    localparam int CAPACITY_DEFAULT = 20;

    // Each display digit is one BCD nibble.
    localparam int BCD_W = 4;

    // Largest value a single BCD digit may hold.
    localparam logic [BCD_W-1:0] BCD_MAX_DIGIT = 4'd9;

endpackage : parking_pkg

// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down register. It steps by one per inc/dec with
// digit carry/borrow. The parent never raises inc and dec together and
// decides whether a step is legal (saturation), so this block never wraps.
module bcd_updown_counter
    import parking_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    logic [BCD_W-1:0] tens_reg;
    logic [BCD_W-1:0] ones_reg;
    logic [BCD_W-1:0] tens_next;
    logic [BCD_W-1:0] ones_next;

    // Next digit values: clear wins, then a single step with carry/borrow.
    always_comb begin
        tens_next = tens_reg;
        ones_next = ones_reg;
        if (clr) begin
            tens_next = '0;
            ones_next = '0;
        end else if (inc) begin
            if (ones_reg == BCD_MAX_DIGIT) begin
                ones_next = '0;
                tens_next = tens_reg + BCD_W'(1);
            end else begin
                ones_next = ones_reg + BCD_W'(1);
            end
        end else if (dec) begin
            if (ones_reg == '0) begin
                ones_next = BCD_MAX_DIGIT;
                tens_next = tens_reg - BCD_W'(1);
            end else begin
                ones_next = ones_reg - BCD_W'(1);
            end
        end
    end

    // Digit registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_reg <= '0;
            ones_reg <= '0;
        end else begin
            tens_reg <= tens_next;
            ones_reg <= ones_next;
        end
    end

    assign tens = tens_reg;
    assign ones = ones_reg;

endmodule : bcd_updown_counter

// File: rtl/parking_occupancy_counter.sv
// Live car count for the lot. Turns entry/exit levels into rising-edge
// events, saturates the count at 0 and CAPACITY, keeps a BCD copy for the
// display, registers full/empty alongside the count and latches sticky
// over/underflow errors for the supervisor.
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = CAPACITY_DEFAULT,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             e_in,
    input  logic             s_in,
    output logic [CNT_W-1:0] count,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             full,
    output logic             empty,
    output logic             chg,
    output logic             ovf_err,
    output logic             udf_err
);

    // Parameter legality is checked at elaboration time.
    if (CAPACITY < 1 || CAPACITY > 99) begin : g_bad_capacity
        $error("parking_occupancy_counter: CAPACITY must be in 1..99");
    end
    if ((1 << CNT_W) <= CAPACITY) begin : g_bad_cnt_w
        $error("parking_occupancy_counter: CNT_W too narrow for CAPACITY");
    end

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic             e_d_reg;
    logic             s_d_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             full_reg;
    logic             full_next;
    logic             empty_reg;
    logic             empty_next;
    logic             chg_reg;
    logic             chg_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             udf_reg;
    logic             udf_next;
    logic             bcd_inc;
    logic             bcd_dec;
    logic             ev_e;
    logic             ev_s;

    // A level held for many cycles yields one event on its rising edge.
    assign ev_e = e_in & ~e_d_reg;
    assign ev_s = s_in & ~s_d_reg;

    // Next-state decision: clear beats coincident events beats a single event.
    always_comb begin
        count_next = count_reg;
        chg_next   = 1'b0;
        ovf_next   = ovf_reg;
        udf_next   = udf_reg;
        bcd_inc    = 1'b0;
        bcd_dec    = 1'b0;
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
            udf_next   = 1'b0;
        end else if (ev_e && ev_s) begin
            // A car in and a car out cancel; nothing to record.
        end else if (ev_e) begin
            if (count_reg < CAP) begin
                count_next = count_reg + CNT_W'(1);
                chg_next   = 1'b1;
                bcd_inc    = 1'b1;
            end else begin
                ovf_next   = 1'b1;
            end
        end else if (ev_s) begin
            if (count_reg != '0) begin
                count_next = count_reg - CNT_W'(1);
                chg_next   = 1'b1;
                bcd_dec    = 1'b1;
            end else begin
                udf_next   = 1'b1;
            end
        end
        // Flags derive from the next count so they land on the same edge.
        full_next  = (count_next == CAP);
        empty_next = (count_next == '0);
    end

    // State registers; edge detectors keep tracking even during clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_d_reg   <= 1'b0;
            s_d_reg   <= 1'b0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
            chg_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            e_d_reg   <= e_in;
            s_d_reg   <= s_in;
            count_reg <= count_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
            chg_reg   <= chg_next;
            ovf_reg   <= ovf_next;
            udf_reg   <= udf_next;
        end
    end

    bcd_updown_counter u_bcd (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .inc  (bcd_inc),
        .dec  (bcd_dec),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );

    assign count   = count_reg;
    assign full    = full_reg;
    assign empty   = empty_reg;
    assign chg     = chg_reg;
    assign ovf_err = ovf_reg;
    assign udf_err = udf_reg;

endmodule : parking_occupancy_counter

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench for parking_occupancy_counter (CAPACITY=20, CNT_W=7).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_parking_occupancy_counter;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       e_in;
    logic       s_in;
    logic [6:0] count;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       full;
    logic       empty;
    logic       chg;
    logic       ovf_err;
    logic       udf_err;

    int checks   = 0;
    int failures = 0;
    int chg_cnt  = 0;
    int chg_base;

    parking_occupancy_counter dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .e_in     (e_in),
        .s_in     (s_in),
        .count    (count),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .full     (full),
        .empty    (empty),
        .chg      (chg),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // chg is a one-cycle pulse, so one sample per falling edge counts it once.
    always @(negedge clk) begin
        if (!rst && chg) chg_cnt = chg_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle stimulus on e/s/clr, result visible at the following
    // falling edge; then idle for two cycles.
    task automatic drive(input bit e, input bit s, input bit c, input int gap);
        @(negedge clk);
        e_in = e; s_in = s; clr = c;
        @(negedge clk);
        e_in = 0; s_in = 0; clr = 0;
        $display("txn e=%0d s=%0d clr=%0d -> count=%0d bcd=%0d/%0d full=%0d empty=%0d chg=%0d ovf=%0d udf=%0d",
                 e, s, c, count, bcd_tens, bcd_ones, full, empty, chg, ovf_err, udf_err);
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_count(input string tag, input int n);
        chk({tag, "_count"}, int'(count), n);
        chk({tag, "_bcd"}, int'(bcd_tens) * 10 + int'(bcd_ones), n);
    endtask

    initial begin
        rst = 1; clr = 0; e_in = 0; s_in = 0;

        // 1. reset
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_tens", int'(bcd_tens), 0);
        chk("rst_ones", int'(bcd_ones), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_chg", int'(chg), 0);
        chk("rst_ovf", int'(ovf_err), 0);
        chk("rst_udf", int'(udf_err), 0);

        // 2. twelve isolated entries, watch the 9 -> 10 digit carry
        chg_base = chg_cnt;
        for (int i = 1; i <= 12; i++) begin
            drive(1, 0, 0, 0);
            chk("inc_chg", int'(chg), 1);
            if (i == 9) begin
                chk("p9_tens", int'(bcd_tens), 0);
                chk("p9_ones", int'(bcd_ones), 9);
            end
            if (i == 10) begin
                chk("p10_tens", int'(bcd_tens), 1);
                chk("p10_ones", int'(bcd_ones), 0);
            end
            repeat (2) @(negedge clk);
        end
        chk_count("t2", 12);
        chk("t2_empty", int'(empty), 0);
        chk("t2_chg_total", chg_cnt - chg_base, 12);

        // 3. fill to capacity, overflow, then one exit
        drive(0, 0, 1, 1);
        chk_count("clr3", 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 1);
        chk_count("cap", 20);
        chk("cap_full", int'(full), 1);
        chk("cap_ovf0", int'(ovf_err), 0);
        chg_base = chg_cnt;
        drive(1, 0, 0, 1);
        chk_count("ovf", 20);
        chk("ovf_flag", int'(ovf_err), 1);
        chk("ovf_no_chg", chg_cnt - chg_base, 0);
        drive(0, 1, 0, 1);
        chk_count("exit19", 19);
        chk("exit19_full", int'(full), 0);
        chk("exit19_ovf", int'(ovf_err), 1);

        // 4. coincident events at 5, then a long held entry level
        drive(0, 0, 1, 1);
        chk("clr4_ovf", int'(ovf_err), 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 1);
        drive(1, 1, 0, 0);
        chk_count("both", 5);
        chk("both_chg", int'(chg), 0);
        chk("both_ovf", int'(ovf_err), 0);
        chk("both_udf", int'(udf_err), 0);
        repeat (2) @(negedge clk);
        chg_base = chg_cnt;
        e_in = 1;
        repeat (4) @(negedge clk);
        e_in = 0;
        repeat (2) @(negedge clk);
        chk_count("held", 6);
        chk("held_chg", chg_cnt - chg_base, 1);

        // 5. underflow at zero, then clr beating an entry
        drive(0, 0, 1, 1);
        chk("clr5_empty", int'(empty), 1);
        drive(0, 1, 0, 1);
        chk_count("udf", 0);
        chk("udf_flag", int'(udf_err), 1);
        chk("udf_empty", int'(empty), 1);
        drive(1, 0, 1, 0);
        chk_count("clr_e", 0);
        chk("clr_e_chg", int'(chg), 0);
        chk("clr_e_udf", int'(udf_err), 0);
        chk("clr_e_ovf", int'(ovf_err), 0);
        repeat (2) @(negedge clk);

        // 6. asynchronous reset between edges at count 7
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 1);
        chk_count("pre_rst", 7);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_bcd", int'(bcd_tens) * 10 + int'(bcd_ones), 0);
        chk("arst_empty", int'(empty), 1);
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1);
        chk_count("post_rst", 3);
        chk("post_rst_tens", int'(bcd_tens), 0);
        chk("post_rst_ones", int'(bcd_ones), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_parking_occupancy_counter
